// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared FSM encoding and widths for the UART TX arbiter
package uart_tx_arb_pkg;
  localparam int BYTE_W = 8;
  localparam int SRC_W = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_XFER} state_t;
endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester/transmitter bundle; slave = arbiter side, master = requesters + transmitter
interface uart_tx_arb_if #(parameter int NUM_REQ = 4);
  import uart_tx_arb_pkg::*;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*BYTE_W-1:0] data_i;
  logic [NUM_REQ-1:0] gnt;
  logic tx_ready;
  logic [BYTE_W-1:0] tx_data_o;
  logic tx_bits_ok;
  logic busy;
  logic [SRC_W-1:0] cur_src;
  logic tx_done;
  logic err;
  modport slave (input req, data_i, tx_bits_ok, output gnt, tx_ready, tx_data_o, busy, cur_src, tx_done, err);
  modport master (output req, data_i, tx_bits_ok, input gnt, tx_ready, tx_data_o, busy, cur_src, tx_done, err);
endinterface

// File: rtl/uart_rr_arb.sv
// uart_rr_arb: combinational round-robin pick, search starts just after last winner
module uart_rr_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SRC_W-1:0]   i_last_winner,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [SRC_W-1:0]   o_idx
);
  int w_best, w_rank;
  // rank = distance from the slot after last winner; lowest requesting rank wins
  always_comb begin
    w_best = NUM_REQ;
    w_rank = 0;
    o_idx = '0;
    o_onehot = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_rank = (j + NUM_REQ - 1 - int'(i_last_winner)) % NUM_REQ;
      if (i_req[j] && w_rank < w_best) begin
        w_best = w_rank;
        o_idx = SRC_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) o_onehot[j] = i_req[j] && (o_idx == SRC_W'(j));
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin byte arbiter feeding a UART transmitter start strobe
// Optional launch watchdog enabled by macro UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic sys_clk,
  input logic rst,
  uart_tx_arb_if.slave bus
);
  state_t r_state, w_state_nx;
  logic [NUM_REQ-1:0] r_gnt, w_onehot;
  logic [SRC_W-1:0] r_cur_src, r_last, w_idx;
  logic [BYTE_W-1:0] r_tx_data, w_byte;
  logic r_tx_ready, r_busy, r_tx_done, w_grant, w_done, w_abort;
  uart_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req(bus.req),
    .i_last_winner(r_last),
    .o_onehot(w_onehot),
    .o_idx(w_idx)
  );
  always_comb begin
    w_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) if (w_onehot[k]) w_byte = bus.data_i[k*BYTE_W +: BYTE_W];
  end
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  logic [WD_W-1:0] r_wd;
  logic r_err;
  wire w_wd_hit = (r_wd == WD_W'(TIMEOUT_CYC - 1));
`else
  wire w_wd_hit = 1'b0;
`endif
  always_comb begin
    w_state_nx = r_state;
    w_grant = 1'b0;
    w_done = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant = bus.tx_bits_ok && |bus.req;
        w_state_nx = w_grant ? ST_LAUNCH : ST_IDLE;
      end
      ST_LAUNCH: begin
        w_abort = bus.tx_bits_ok && w_wd_hit;
        w_state_nx = !bus.tx_bits_ok ? ST_XFER : (w_abort ? ST_IDLE : ST_LAUNCH);
      end
      ST_XFER: begin
        w_done = bus.tx_bits_ok;
        w_state_nx = w_done ? ST_IDLE : ST_XFER;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt <= '0;
      r_tx_ready <= 1'b0;
      r_tx_data <= '0;
      r_cur_src <= '0;
      r_last <= SRC_W'(NUM_REQ - 1);
      r_busy <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_gnt <= w_grant ? w_onehot : '0;
      r_tx_ready <= (w_state_nx == ST_LAUNCH);
      r_busy <= (w_state_nx != ST_IDLE);
      r_tx_done <= w_done;
      if (w_grant) begin
        r_tx_data <= w_byte;
        r_cur_src <= w_idx;
        r_last <= w_idx;
      end
    end
  end
`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_wd <= '0;
      r_err <= 1'b0;
    end else begin
      r_wd <= (r_state == ST_LAUNCH && w_state_nx == ST_LAUNCH) ? r_wd + 1'b1 : '0;
      r_err <= w_abort;
    end
  end
  assign bus.err = r_err;
`else
  assign bus.err = (TIMEOUT_CYC < 0);
`endif
  assign bus.gnt = r_gnt;
  assign bus.tx_ready = r_tx_ready;
  assign bus.tx_data_o = r_tx_data;
  assign bus.busy = r_busy;
  assign bus.cur_src = r_cur_src;
  assign bus.tx_done = r_tx_done;
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed checks of grant order, handshake timing, data hold, reset abort, watchdog
module tb_uart_tx_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  uart_tx_arb_if #(.NUM_REQ(4)) bus ();
  uart_tx_arb #(.NUM_REQ(4), .TIMEOUT_CYC(16)) dut (.sys_clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 0);
    chk({tag, "_rdy"}, 32'(bus.tx_ready), 0);
    chk({tag, "_data"}, 32'(bus.tx_data_o), 0);
    chk({tag, "_src"}, 32'(bus.cur_src), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.tx_done), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
  endtask
  initial begin
    bus.req = '0;
    bus.data_i = '0;
    bus.tx_bits_ok = 1'b0;
    step();
    step();
    chk_reset_outputs("rst");
    rst = 1'b0;
    bus.req = 4'b0010;
    bus.data_i[15:8] = 8'hA5;
    step();
    step();
    chk("wait_gnt", 32'(bus.gnt), 0);
    chk("wait_busy", 32'(bus.busy), 0);
    bus.tx_bits_ok = 1'b1;
    step();
    chk("single_gnt", 32'(bus.gnt), 32'b0010);
    chk("single_data", 32'(bus.tx_data_o), 32'hA5);
    chk("single_src", 32'(bus.cur_src), 1);
    chk("single_rdy", 32'(bus.tx_ready), 1);
    chk("single_busy", 32'(bus.busy), 1);
    bus.req = '0;
    step();
    chk("single_gnt_pulse", 32'(bus.gnt), 0);
    chk("single_rdy_hold", 32'(bus.tx_ready), 1);
    bus.tx_bits_ok = 1'b0;
    step();
    chk("single_rdy_drop", 32'(bus.tx_ready), 0);
    chk("single_xfer_busy", 32'(bus.busy), 1);
    step();
    chk("single_no_done", 32'(bus.tx_done), 0);
    bus.tx_bits_ok = 1'b1;
    step();
    chk("single_done", 32'(bus.tx_done), 1);
    chk("single_done_src", 32'(bus.cur_src), 1);
    chk("single_done_busy", 32'(bus.busy), 0);
    step();
    chk("single_done_pulse", 32'(bus.tx_done), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 4'b1111;
    bus.data_i = 32'h13121110;
    for (int f = 0; f < 5; f++) begin
      step();
      chk("rr_gnt", 32'(bus.gnt), 32'(1 << (f % 4)));
      chk("rr_data", 32'(bus.tx_data_o), 32'h10 + 32'(f % 4));
      step();
      chk("rr_gnt_once", 32'(bus.gnt), 0);
      bus.tx_bits_ok = 1'b0;
      step();
      chk("rr_rdy_low_xfer", 32'(bus.tx_ready), 0);
      bus.tx_bits_ok = 1'b1;
      step();
      chk("rr_done", 32'(bus.tx_done), 1);
      chk("rr_rdy_low_done", 32'(bus.tx_ready), 0);
      chk("rr_done_src", 32'(bus.cur_src), 32'(f % 4));
    end
    bus.req = 4'b0100;
    bus.data_i[23:16] = 8'hC3;
    step();
    chk("hold_gnt", 32'(bus.gnt), 32'b0100);
    bus.data_i[23:16] = 8'h00;
    bus.req = '0;
    step();
    chk("hold_launch", 32'(bus.tx_data_o), 32'hC3);
    bus.tx_bits_ok = 1'b0;
    step();
    chk("hold_xfer", 32'(bus.tx_data_o), 32'hC3);
    bus.tx_bits_ok = 1'b1;
    bus.req = 4'b0101;
    step();
    chk("hold_done", 32'(bus.tx_done), 1);
    chk("hold_done_data", 32'(bus.tx_data_o), 32'hC3);
    chk("hold_done_src", 32'(bus.cur_src), 2);
    step();
    chk("fair_gnt", 32'(bus.gnt), 32'b0001);
    chk("fair_src", 32'(bus.cur_src), 0);
    bus.req = 4'b0001;
    step();
    bus.tx_bits_ok = 1'b0;
    step();
    chk("xfer_pre_rst_busy", 32'(bus.busy), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    bus.req = 4'b0011;
    bus.tx_bits_ok = 1'b1;
    step();
    chk_reset_outputs("rst_hold");
    rst = 1'b0;
    step();
    chk("post_rst_gnt", 32'(bus.gnt), 32'b0001);
    chk("post_rst_src", 32'(bus.cur_src), 0);
    bus.req = '0;
    step();
    bus.tx_bits_ok = 1'b0;
    step();
    bus.tx_bits_ok = 1'b1;
    step();
    chk("post_rst_done", 32'(bus.tx_done), 1);
    bus.req = 4'b1000;
    step();
    chk("wd_gnt", 32'(bus.gnt), 32'b1000);
    bus.req = '0;
    for (int c = 0; c < 15; c++) step();
    chk("wd_pre_err", 32'(bus.err), 0);
    chk("wd_pre_busy", 32'(bus.busy), 1);
    step();
`ifdef UART_TX_ARB_TIMEOUT_EN
    chk("wd_err", 32'(bus.err), 1);
    chk("wd_rdy", 32'(bus.tx_ready), 0);
    chk("wd_busy", 32'(bus.busy), 0);
    chk("wd_no_done", 32'(bus.tx_done), 0);
    step();
    chk("wd_err_pulse", 32'(bus.err), 0);
    chk("wd_no_regrant", 32'(bus.gnt), 0);
`else
    chk("nowd_err", 32'(bus.err), 0);
    chk("nowd_rdy", 32'(bus.tx_ready), 1);
    chk("nowd_busy", 32'(bus.busy), 1);
    bus.tx_bits_ok = 1'b0;
    step();
    bus.tx_bits_ok = 1'b1;
    step();
    chk("nowd_done", 32'(bus.tx_done), 1);
    chk("nowd_done_src", 32'(bus.cur_src), 3);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
